lfsr_decrypt_engine: RTL and testbench

- Hardware decryptor for the message-encryption protocol.
- Reads the 64-byte LFSR-encrypted, space-padded message from data memory DM[64..127].
- Recovers the feedback tap pattern and starting state from the known-space preamble.
- Decrypts the message, strips leading spaces, and writes the plaintext to DM[0..40].
- Sits beside data memory as a memory master: the fixed-function counterpart to the encrypting program, exercised by the same bench flow (start high = load/reset, wait for done).

---
 rtl/crypt_pkg.sv | 38 +++
 rtl/lfsr8_step.sv | 17 +
 rtl/lfsr_decrypt_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_lfsr_decrypt_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// crypt_pkg
// Shared constants and helpers for the LFSR message decryptor:
//   - TAP_ROM   : candidate feedback tap patterns, tested in index order
//   - SPACE     : pad / preamble byte of the plaintext
//   - memory map: plaintext window DM[MSG_BASE +: MSG_LEN],
//                 ciphertext window DM[CT_BASE +: CT_LEN]
//   - PRE_MIN   : number of known-space preamble bytes used for recovery
//   - state_e   : decryptor FSM states
//   - lfsr_next : one step of the 8-bit Fibonacci-style LFSR
package crypt_pkg;

    localparam int unsigned MSG_BASE = 0;
    localparam int unsigned MSG_LEN  = 41;
    localparam int unsigned CT_BASE  = 64;
    localparam int unsigned CT_LEN   = 64;
    localparam int unsigned PRE_MIN  = 9;

    localparam logic [7:0] SPACE = 8'h20;

    localparam logic [7:0] TAP_ROM [0:7] = '{
        8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3
    };

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_DECRYPT = 3'd3,
        ST_PAD     = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Shift left, feeding back the parity of the tapped bits into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] p);
        return {s[6:0], ^(s & p)};
    endfunction

endpackage

// File: rtl/lfsr8_step.sv
// lfsr8_step
// Combinational single step of the 8-bit LFSR.
// Ports:
//   state      in  8  current LFSR state
//   taps       in  8  feedback tap pattern
//   state_next out 8  state after one step
module lfsr8_step
    import crypt_pkg::*;
(
    input  logic [7:0] state,
    input  logic [7:0] taps,
    output logic [7:0] state_next
);

    assign state_next = lfsr_next(state, taps);

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine
// Memory-master decryptor. After start falls it reads the preamble of the
// ciphertext, recovers the LFSR tap pattern and starting state, decrypts the
// 64-byte message, strips leading spaces and writes up to 41 plaintext bytes
// (space padded) to DM[0..40].
// Ports:
//   CLK          in  1  system clock, rising edge
//   start        in  1  synchronous active-high reset; run begins when it falls
//   mem_rd_data  in  8  read data, valid the cycle after mem_addr
//   mem_addr     out 8  data memory address
//   mem_wr_en    out 1  write strobe (memory writes on the closing edge)
//   mem_wr_data  out 8  write data
//   done         out 1  run finished, held until start
//   err          out 1  no candidate tap pattern fits the preamble
//   tap_ptrn     out 8  recovered tap pattern
//   seed         out 8  recovered starting state s0
module lfsr_decrypt_engine
    import crypt_pkg::*;
(
    input  logic       CLK,
    input  logic       start,
    input  logic [7:0] mem_rd_data,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic       done,
    output logic       err,
    output logic [7:0] tap_ptrn,
    output logic [7:0] seed
);

    localparam logic [7:0] CT_BASE_A  = 8'(CT_BASE);
    localparam logic [7:0] MSG_BASE_A = 8'(MSG_BASE);
    localparam logic [5:0] MSG_END    = 6'(MSG_LEN);
    localparam logic [5:0] MSG_LAST   = 6'(MSG_LEN - 1);
    localparam logic [5:0] CT_LAST    = 6'(CT_LEN - 1);
    localparam logic [3:0] LOAD_LAST  = 4'(PRE_MIN);      // final capture cycle
    localparam logic [3:0] LOAD_ADDRS = 4'(PRE_MIN - 1);  // address advances while below
    localparam logic [3:0] SRCH_LAST  = 4'd7;

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;        // LOAD / SEARCH cycle counter
    logic [5:0]               byte_q, byte_d;      // ciphertext byte index
    logic                     phase_q, phase_d;    // 0: address cycle, 1: data cycle
    logic [5:0]               wp_q, wp_d;          // plaintext write pointer
    logic                     lead_q, lead_d;      // still inside leading spaces
    logic [7:0]               lfsr_q, lfsr_d;
    logic [PRE_MIN-1:0][7:0]  k_q, k_d;            // preamble states s0..s8
    logic [7:0]               addr_q, addr_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [7:0]               tap_q, tap_d;
    logic [7:0]               seed_q, seed_d;

    // SEARCH: check all preamble transitions against one ROM entry per cycle.
    logic [7:0]         cand_tap;
    logic [PRE_MIN-2:0] tap_fit;

    assign cand_tap = TAP_ROM[cnt_q[2:0]];

    genvar gi;
    generate
        for (gi = 0; gi < PRE_MIN - 1; gi++) begin : g_chk
            logic [7:0] chk_next;
            lfsr8_step u_chk (
                .state      (k_q[gi]),
                .taps       (cand_tap),
                .state_next (chk_next)
            );
            assign tap_fit[gi] = (chk_next == k_q[gi+1]);
        end
    endgenerate

    // DECRYPT keystream stepping.
    logic [7:0] lfsr_step;
    lfsr8_step u_dec (
        .state      (lfsr_q),
        .taps       (tap_q),
        .state_next (lfsr_step)
    );

    logic [7:0] plain;
    logic       keep_byte;
    logic [5:0] wp_inc;
    logic [5:0] wp_after;

    assign plain     = mem_rd_data ^ lfsr_q;
    assign keep_byte = (state_q == ST_DECRYPT) && phase_q && (wp_q < MSG_END) &&
                       !(lead_q && (plain == SPACE));
    assign wp_inc    = wp_q + 6'd1;
    assign wp_after  = keep_byte ? wp_inc : wp_q;

    // The keep decision depends on read data that only arrives in the data
    // cycle, so the strobe is decoded combinationally from registered state.
    // Gating with start keeps any edge that samples start=1 write-free.
    assign mem_wr_en   = !start && (keep_byte || (state_q == ST_PAD));
    assign mem_wr_data = (state_q == ST_PAD) ? SPACE :
                         keep_byte           ? plain : 8'h00;

    assign mem_addr = addr_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tap_ptrn = tap_q;
    assign seed     = seed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        phase_d = phase_q;
        wp_d    = wp_q;
        lead_d  = lead_q;
        lfsr_d  = lfsr_q;
        k_d     = k_q;
        addr_d  = addr_q;
        done_d  = done_q;
        err_d   = err_q;
        tap_d   = tap_q;
        seed_d  = seed_q;

        case (state_q)
            ST_IDLE: begin
                addr_d  = CT_BASE_A;
                cnt_d   = 4'd0;
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                // Read data lags the address by one cycle, so cycle c
                // captures the byte addressed in cycle c-1.
                if (cnt_q != 4'd0) begin
                    k_d[cnt_q - 4'd1] = mem_rd_data ^ SPACE;
                end
                if (cnt_q < LOAD_ADDRS) begin
                    addr_d = addr_q + 8'd1;
                end
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_SEARCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_SEARCH: begin
                if (&tap_fit) begin
                    tap_d   = cand_tap;
                    seed_d  = k_q[0];
                    lfsr_d  = k_q[0];
                    addr_d  = CT_BASE_A;
                    byte_d  = 6'd0;
                    phase_d = 1'b0;
                    state_d = ST_DECRYPT;
                end else if (cnt_q == SRCH_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_DECRYPT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    // Once the plaintext window is full the address stays on
                    // the ciphertext byte instead of pointing past DM[40].
                    if (wp_q < MSG_END) begin
                        addr_d = MSG_BASE_A + {2'b00, wp_q};
                    end
                end else begin
                    phase_d = 1'b0;
                    lfsr_d  = lfsr_step;
                    if (keep_byte) begin
                        wp_d   = wp_inc;
                        lead_d = 1'b0;
                    end
                    if (byte_q == CT_LAST) begin
                        if (wp_after < MSG_END) begin
                            addr_d  = MSG_BASE_A + {2'b00, wp_after};
                            state_d = ST_PAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        byte_d = byte_q + 6'd1;
                        addr_d = CT_BASE_A + {2'b00, byte_q} + 8'd1;
                    end
                end
            end

            ST_PAD: begin
                wp_d = wp_inc;
                if (wp_q == MSG_LAST) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d = MSG_BASE_A + {2'b00, wp_inc};
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            byte_q  <= 6'd0;
            phase_q <= 1'b0;
            wp_q    <= 6'd0;
            lead_q  <= 1'b1;
            lfsr_q  <= 8'h00;
            k_q     <= '0;
            addr_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tap_q   <= 8'h00;
            seed_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            phase_q <= phase_d;
            wp_q    <= wp_d;
            lead_q  <= lead_d;
            lfsr_q  <= lfsr_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tap_q   <= tap_d;
            seed_q  <= seed_d;
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// tb_lfsr_decrypt_engine
// Scoreboard bench: each run encrypts a message with a behavioural LFSR
// model, predicts recovery/decryption at message level and queues the
// expected plaintext writes; a monitor pops and compares every write strobe.
module tb_lfsr_decrypt_engine;

    logic       CLK = 1'b0;
    logic       start = 1'b1;
    logic [7:0] mem_rd_data;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic       done;
    logic       err;
    logic [7:0] tap_ptrn;
    logic [7:0] seed;

    always #5 CLK = ~CLK;

    lfsr_decrypt_engine dut (
        .CLK         (CLK),
        .start       (start),
        .mem_rd_data (mem_rd_data),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .done        (done),
        .err         (err),
        .tap_ptrn    (tap_ptrn),
        .seed        (seed)
    );

    // Data memory model with a one-cycle registered read.
    logic [7:0] mem    [0:255];
    logic [7:0] ct_img [0:63];
    logic       load_req = 1'b0;

    always @(posedge CLK) begin
        mem_rd_data <= mem[mem_addr];
        if (load_req) begin
            for (int j = 0; j < 64; j++) mem[64+j] <= ct_img[j];
            for (int j = 0; j < 41; j++) mem[j] <= 8'hEE;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
        end
    end

    logic [7:0]  rom [0:7] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          max_addr = 0;

    // Feedback bit = odd number of tapped ones; state shifts up by one.
    function automatic logic [7:0] m_step(input logic [7:0] s, input logic [7:0] p);
        int ones;
        logic [8:0] sh;
        ones = 0;
        for (int b = 0; b < 8; b++) if (s[b] && p[b]) ones++;
        sh = {s, 1'b0};
        return sh[7:0] | {7'b0, ones[0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic chk_reset(input string nm);
        n_checks++;
        if (mem_addr !== 8'h00 || mem_wr_en !== 1'b0 || mem_wr_data !== 8'h00 || done !== 1'b0 ||
            err !== 1'b0 || tap_ptrn !== 8'h00 || seed !== 8'h00) begin
            n_errors++;
            $display("FAIL %s: addr=%0h we=%b wd=%0h done=%b err=%b tap=%0h seed=%0h, required all zero",
                     nm, mem_addr, mem_wr_en, mem_wr_data, done, err, tap_ptrn, seed);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge CLK);
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (mem_wr_en === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%0h, required no write", mem_addr, mem_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wr_data} !== e) begin
                        n_errors++;
                        $display("FAIL write: addr=%0d data=%0h, required addr=%0d data=%0h",
                                 mem_addr, mem_wr_data, e[15:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic run_case(input string name, input logic [7:0] p, input logic [7:0] s0, input int pre,
                            input string txt, input bit corrupt, input int abort_at);
        logic [7:0] msg    [0:63];
        logic [7:0] pl     [0:63];
        logic [7:0] st     [0:8];
        logic [7:0] exp_dm [0:40];
        logic [7:0] lf;
        logic [7:0] exp_tap;
        logic [7:0] exp_seed;
        int idx, kept, f, cyc, exp_cyc;
        bit fits, exp_err, got_done, dm_ok;

        // Build and encrypt the message: preamble spaces, text, space padding.
        for (int i = 0; i < 64; i++) msg[i] = 8'h20;
        for (int j = 0; j < txt.len(); j++) if (pre + j < 64) msg[pre+j] = txt[j];
        lf = s0;
        for (int i = 0; i < 64; i++) begin
            ct_img[i] = msg[i] ^ lf;
            lf = m_step(lf, p);
        end
        if (corrupt) for (int i = 0; i < 9; i++) ct_img[i] = 8'h21;

        // Reference: lowest ROM entry consistent with the preamble states.
        for (int i = 0; i < 9; i++) st[i] = ct_img[i] ^ 8'h20;
        idx = -1;
        for (int c = 0; c < 8; c++) begin
            if (idx < 0) begin
                fits = 1'b1;
                for (int i = 0; i < 8; i++) if (m_step(st[i], rom[c]) != st[i+1]) fits = 1'b0;
                if (fits) idx = c;
            end
        end
        exp_err  = (idx < 0);
        exp_tap  = 8'h00;
        exp_seed = 8'h00;
        kept     = 0;
        exp_q.delete();
        if (!exp_err) begin
            exp_tap  = rom[idx];
            exp_seed = st[0];
            lf = st[0];
            for (int i = 0; i < 64; i++) begin
                pl[i] = ct_img[i] ^ lf;
                lf = m_step(lf, exp_tap);
            end
            f = 0;
            while (f < 64 && pl[f] == 8'h20) f++;
            for (int i = f; i < 64 && kept < 41; i++) begin
                exp_dm[kept] = pl[i];
                kept++;
            end
            for (int a = kept; a < 41; a++) exp_dm[a] = 8'h20;
            for (int a = 0; a < 41; a++) exp_q.push_back({8'(a), exp_dm[a]});
            exp_cyc = 140 + idx + (41 - kept);
        end else begin
            exp_cyc = 19;
        end

        // Hold reset, load memory, check reset outputs.
        @(posedge CLK); #1 start = 1'b1; load_req = 1'b1;
        @(posedge CLK); #1 load_req = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk_reset({name, "_reset"});
        max_addr = 0;
        @(posedge CLK); #1 start = 1'b0;

        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 400) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            if (cyc == 1) chk({name, "_first_addr"}, 32'(mem_addr), 32'd64);
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else if (abort_at > 0 && cyc == abort_at) begin
                @(posedge CLK); #1 start = 1'b1;
                exp_q.delete();
                @(posedge CLK);
                @(negedge CLK);
                chk_reset({name, "_abort_reset"});
                $display("run %s: aborted at cycle %0d", name, cyc);
                return;
            end
        end

        chk({name, "_done_seen"}, 32'(got_done), 32'd1);
        chk({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_within_188"}, 32'(cyc <= 188), 32'd1);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        if (!exp_err) begin
            chk({name, "_tap"}, 32'(tap_ptrn), 32'(exp_tap));
            chk({name, "_seed"}, 32'(seed), 32'(exp_seed));
        end
        repeat (3) @(negedge CLK);
        chk({name, "_done_held"}, 32'(done), 32'd1);
        chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        dm_ok = 1'b1;
        for (int a = 0; a < 41; a++) begin
            if (exp_err) begin
                if (mem[a] !== 8'hEE) dm_ok = 1'b0;
            end else if (mem[a] !== exp_dm[a]) begin
                dm_ok = 1'b0;
            end
        end
        chk({name, "_dm_contents"}, 32'(dm_ok), 32'd1);
        chk({name, "_addr_max"}, 32'(max_addr <= 127), 32'd1);
        $display("run %s: tap=%0h seed=%0h err=%b cycles=%0d kept=%0d", name, tap_ptrn, seed, err, cyc, kept);
    endtask

    initial begin
        logic [7:0] s;
        string t;
        int pre, lead_sp, len;

        run_case("joke", 8'hfa, 8'h48, 10, "  f       A joke is a very serious thing.", 1'b0, 0);
        chk("joke_dm64", 32'(mem[64]), 32'h68);

        s = 8'($urandom_range(0, 255)) | 8'h40;
        run_case("wisdom", 8'hd4, s, 9, "Knowledge comes, but wisdom lingers.     ", 1'b0, 0);

        s = 8'($urandom_range(1, 255));
        run_case("all_space", 8'he1, s, 64, "", 1'b0, 0);

        s = 8'($urandom_range(1, 255));
        run_case("no_fit", 8'hb4, s, 9, "Corrupted preamble", 1'b1, 0);

        s = 8'($urandom_range(1, 255)) | 8'h01;
        run_case("abort", 8'hc6, s, 12, "Interrupted mid decrypt, then rerun.", 1'b0, 60);
        run_case("rerun", 8'hc6, s, 12, "Interrupted mid decrypt, then rerun.", 1'b0, 0);

        run_case("b2b_b2", 8'hb2, 8'h5a, 9, "First of two back to back runs.", 1'b0, 0);
        run_case("b2b_b8", 8'hb8, 8'hc3, 11, "Second run only.", 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            pre     = int'($urandom_range(9, 20));
            lead_sp = int'($urandom_range(0, 5));
            len     = int'($urandom_range(0, 64 - pre));
            t = "";
            for (int c = 0; c < len; c++) begin
                if (c < lead_sp) t = {t, " "};
                else t = {t, $sformatf("%c", 8'($urandom_range(32, 126)))};
            end
            s = 8'($urandom_range(1, 255));
            run_case($sformatf("rand%0d", r), rom[$urandom_range(0, 7)], s, pre, t, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
